// File: rtl/ic9_env_encoder_pkg.sv
// Shared widths, FSM state type and IC11 ROM byte scramble positions for the IC9 envelope format.
package rdpiano_env_pkg;

   localparam int unsigned ENV_LIN_W  = 19;
   localparam int unsigned ENV_MANT_W = 13;
   localparam int unsigned ENV_EXP_W  = 4;
   localparam logic [ENV_EXP_W-1:0] ENV_EXP_MAX = 4'd11;

   typedef enum logic [1:0] {
      ENC_IDLE  = 2'd0,
      ENC_NORM  = 2'd1,
      ENC_PACK0 = 2'd2,
      ENC_PACK1 = 2'd3
   } env_enc_state_t;

   // Destination bit of mantissa bit i: m[7:0] land in byte0, m[12:8] in byte1.
   localparam logic [2:0] SCR_POS [ENV_MANT_W] = '{
      3'd1, 3'd2, 3'd6, 3'd4, 3'd3, 3'd5, 3'd0, 3'd7,
      3'd1, 3'd2, 3'd6, 3'd4, 3'd3
   };

endpackage

// File: rtl/ic9_env_encoder_if.sv
// Value-in / byte-out stream bundle of the IC9 envelope encoder.
interface ic9_env_encoder_if;
   import rdpiano_env_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [ENV_LIN_W-1:0]  in_value;
   logic                  out_valid;
   logic                  out_ready;
   logic [7:0]            out_byte;
   logic                  out_last;
   logic [ENV_EXP_W-1:0]  out_exp;
   logic                  out_uflow;

   modport master (
      output in_valid, in_value, out_ready,
      input  in_ready, out_valid, out_byte, out_last, out_exp, out_uflow
   );

   modport slave (
      input  in_valid, in_value, out_ready,
      output in_ready, out_valid, out_byte, out_last, out_exp, out_uflow
   );
endinterface

// File: rtl/ic11_byte_scrambler.sv
// Combinational mapping of a 13-bit envelope mantissa onto the two scrambled IC11 ROM bytes.
module ic11_byte_scrambler
   import rdpiano_env_pkg::*;
(
   input  logic [ENV_MANT_W-1:0] mant,
   output logic [7:0]            byte0,
   output logic [7:0]            byte1
);

   always_comb begin
      byte0 = '0;
      byte1 = '0;
      for (int i = 0; i < 8; i++) begin
         byte0[SCR_POS[i]] = mant[i];
      end
      for (int i = 8; i < int'(ENV_MANT_W); i++) begin
         byte1[SCR_POS[i]] = mant[i];
      end
   end

endmodule

// File: rtl/ic9_env_encoder.sv
// IC9 envelope encoder: normalises a linear value into (e, mantissa) and streams two ROM bytes.
// Build option: ENV_ENC_ROUND_EN selects round-half-up instead of truncation of the mantissa.
//
// state | meaning
// IDLE  | waiting for a value, in_ready high
// NORM  | shifting left one bit per cycle until bit 18 is set or e hits 0
// PACK0 | presenting byte0 (even address)
// PACK1 | presenting byte1 (odd address), out_last high
module ic9_env_encoder
   import rdpiano_env_pkg::*;
(
   input logic              clk,
   input logic              rst,
   ic9_env_encoder_if.slave bus
);

   env_enc_state_t         state_q, state_d;
   logic [ENV_LIN_W-1:0]   sh_q, sh_d;
   logic [ENV_EXP_W-1:0]   e_q, e_d;
   logic [ENV_MANT_W-1:0]  m_q, m_d;
   logic                   uflow_q, uflow_d;
   logic [ENV_MANT_W-1:0]  m_trunc;
   logic [7:0]             byte0, byte1;

   assign m_trunc = sh_q[ENV_LIN_W-2 -: ENV_MANT_W];

   ic11_byte_scrambler u_scrambler (
      .mant  (m_q),
      .byte0 (byte0),
      .byte1 (byte1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ENC_IDLE;
         sh_q    <= '0;
         e_q     <= '0;
         m_q     <= '0;
         uflow_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         e_q     <= e_d;
         m_q     <= m_d;
         uflow_q <= uflow_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      e_d     = e_q;
      m_d     = m_q;
      uflow_d = uflow_q;
      unique case (state_q)
         ENC_IDLE: begin
            if (bus.in_valid) begin
               sh_d    = bus.in_value;
               e_d     = ENV_EXP_MAX;
               m_d     = '0;
               uflow_d = 1'b0;
               state_d = ENC_NORM;
            end
         end
         ENC_NORM: begin
            if (sh_q[ENV_LIN_W-1]) begin
               m_d     = m_trunc;
`ifdef ENV_ENC_ROUND_EN
               // A carry out of the mantissa bumps the exponent; at the top code it saturates.
               if (sh_q[4]) begin
                  if (&m_trunc) begin
                     if (e_q == ENV_EXP_MAX) begin
                        m_d = '1;
                     end else begin
                        m_d = '0;
                        e_d = e_q + ENV_EXP_W'(1);
                     end
                  end else begin
                     m_d = m_trunc + ENV_MANT_W'(1);
                  end
               end
`endif
               state_d = ENC_PACK0;
            end else if (e_q == '0) begin
               m_d     = '0;
               uflow_d = 1'b1;
               state_d = ENC_PACK0;
            end else begin
               sh_d = {sh_q[ENV_LIN_W-2:0], 1'b0};
               e_d  = e_q - ENV_EXP_W'(1);
            end
         end
         ENC_PACK0: begin
            if (bus.out_ready) state_d = ENC_PACK1;
         end
         ENC_PACK1: begin
            if (bus.out_ready) state_d = ENC_IDLE;
         end
         default: state_d = ENC_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == ENC_IDLE);
      bus.out_valid = (state_q == ENC_PACK0) || (state_q == ENC_PACK1);
      bus.out_last  = (state_q == ENC_PACK1);
      bus.out_byte  = '0;
      bus.out_exp   = '0;
      bus.out_uflow = 1'b0;
      if (state_q == ENC_PACK0) bus.out_byte = byte0;
      if (state_q == ENC_PACK1) bus.out_byte = byte1;
      if (bus.out_valid) begin
         bus.out_exp   = e_q;
         bus.out_uflow = uflow_q;
      end
   end

endmodule

// File: tb/tb_ic9_env_encoder.sv
// Directed bench for ic9_env_encoder: known vectors, handshake hold, mid-run reset, decode round-trip.
module tb_ic9_env_encoder;
   import rdpiano_env_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   ic9_env_encoder_if bus ();

   ic9_env_encoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] b0, b1;
   logic [3:0] e0, e1;
   logic       u0, u1, l0, l1, v1;
   int         lat;
   bit         to;

   // Offers one value and drains both beats with out_ready high; records what was seen.
   task automatic run_txn(input logic [18:0] v);
      int n;
      to = 1'b0;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) to = 1'b1;
      bus.in_value = v;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      lat = 1;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!bus.out_valid && lat < 40);
      if (!bus.out_valid) to = 1'b1;
      b0 = bus.out_byte; e0 = bus.out_exp; u0 = bus.out_uflow; l0 = bus.out_last;
      bus.out_ready = 1'b1;
      @(negedge clk);
      b1 = bus.out_byte; e1 = bus.out_exp; u1 = bus.out_uflow; l1 = bus.out_last; v1 = bus.out_valid;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (bus.out_byte !== 8'h00) begin failures++; $display("FAIL reset_out_byte got=%h exp=00", bus.out_byte); end
      checks++; if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
      checks++; if (bus.out_exp !== 4'd0) begin failures++; $display("FAIL reset_out_exp got=%0d exp=0", bus.out_exp); end
      checks++; if (bus.out_uflow !== 1'b0) begin failures++; $display("FAIL reset_out_uflow got=%b exp=0", bus.out_uflow); end
   endtask

   task automatic test_top_bit();
      run_txn(19'h40000);
      checks++; if (to) begin failures++; $display("FAIL top_bit_timeout got=1 exp=0"); end
      checks++; if (lat !== 2) begin failures++; $display("FAIL top_bit_latency got=%0d exp=2", lat); end
      checks++; if (e0 !== 4'd11 || e1 !== 4'd11) begin failures++; $display("FAIL top_bit_exp got=%0d/%0d exp=11", e0, e1); end
      checks++; if (b0 !== 8'h00 || b1 !== 8'h00) begin failures++; $display("FAIL top_bit_bytes got=%h %h exp=00 00", b0, b1); end
      checks++; if (l0 !== 1'b0 || l1 !== 1'b1 || v1 !== 1'b1) begin failures++; $display("FAIL top_bit_last got=%b%b valid=%b exp=01 valid=1", l0, l1, v1); end
      checks++; if (u0 !== 1'b0 || u1 !== 1'b0) begin failures++; $display("FAIL top_bit_uflow got=%b%b exp=00", u0, u1); end
   endtask

   task automatic test_full_scale();
      run_txn(19'h7FFFF);
      checks++; if (to) begin failures++; $display("FAIL full_timeout got=1 exp=0"); end
      checks++; if (e0 !== 4'd11) begin failures++; $display("FAIL full_exp got=%0d exp=11", e0); end
      checks++; if (b0 !== 8'hFF || b1 !== 8'h5E) begin failures++; $display("FAIL full_bytes got=%h %h exp=FF 5E", b0, b1); end
   endtask

   task automatic test_rounding();
      run_txn(19'h0FFFF);
      checks++; if (to) begin failures++; $display("FAIL round_timeout got=1 exp=0"); end
`ifdef ENV_ENC_ROUND_EN
      checks++; if (e0 !== 4'd9 || e1 !== 4'd9) begin failures++; $display("FAIL round_exp got=%0d/%0d exp=9", e0, e1); end
      checks++; if (b0 !== 8'h00 || b1 !== 8'h00) begin failures++; $display("FAIL round_bytes got=%h %h exp=00 00", b0, b1); end
`else
      checks++; if (e0 !== 4'd8 || e1 !== 4'd8) begin failures++; $display("FAIL trunc_exp got=%0d/%0d exp=8", e0, e1); end
      checks++; if (b0 !== 8'hFF || b1 !== 8'h5E) begin failures++; $display("FAIL trunc_bytes got=%h %h exp=FF 5E", b0, b1); end
`endif
   endtask

   task automatic test_underflow();
      logic [18:0] vals [3] = '{19'h00080, 19'h0003F, 19'h00000};
      for (int i = 0; i < 3; i++) begin
         run_txn(vals[i]);
         checks++; if (to) begin failures++; $display("FAIL low_timeout val=%h got=1 exp=0", vals[i]); end
         checks++; if (e0 !== 4'd0 || e1 !== 4'd0) begin failures++; $display("FAIL low_exp val=%h got=%0d/%0d exp=0", vals[i], e0, e1); end
         checks++; if (b0 !== 8'h00 || b1 !== 8'h00) begin failures++; $display("FAIL low_bytes val=%h got=%h %h exp=00 00", vals[i], b0, b1); end
         checks++; if (u0 !== (i != 0) || u1 !== (i != 0)) begin failures++; $display("FAIL low_uflow val=%h got=%b%b exp=%b", vals[i], u0, u1, (i != 0)); end
         if (i == 0) begin
            checks++; if (lat !== 13) begin failures++; $display("FAIL low_latency got=%0d exp=13", lat); end
         end
      end
   endtask

   task automatic test_hold();
      int n = 0;
      @(negedge clk);
      bus.in_value = 19'h7FFFF;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      do begin @(negedge clk); n++; end while (!bus.out_valid && n < 40);
      checks++; if (!bus.out_valid) begin failures++; $display("FAIL hold_timeout got=0 exp=1"); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'hFF || bus.out_exp !== 4'd11 ||
             bus.out_last !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL hold_stable cyc=%0d got=v%b b%h e%0d l%b r%b exp=v1 bFF e11 l0 r0",
                     i, bus.out_valid, bus.out_byte, bus.out_exp, bus.out_last, bus.in_ready);
         end
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.out_byte !== 8'h5E || bus.out_last !== 1'b1 || bus.in_ready !== 1'b0) begin
         failures++; $display("FAIL hold_beat1 got=b%h l%b r%b exp=b5E l1 r0", bus.out_byte, bus.out_last, bus.in_ready);
      end
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++; $display("FAIL hold_done got=v%b r%b exp=v0 r1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      bus.in_value = 19'h00080;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.in_ready); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_exp !== 4'd0 || bus.out_byte !== 8'h00) begin
         failures++; $display("FAIL midrst_outputs got=v%b r%b e%0d b%h exp=v0 r1 e0 b00", bus.out_valid, bus.in_ready, bus.out_exp, bus.out_byte);
      end
      repeat (15) begin
         @(negedge clk);
         checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_beat got=1 exp=0"); end
      end
   endtask

   task automatic test_back_to_back();
      run_txn(19'h20000);
      checks++; if (to || e0 !== 4'd10 || b0 !== 8'h00 || b1 !== 8'h00) begin
         failures++; $display("FAIL b2b_first got=e%0d %h %h to=%b exp=e10 00 00 to=0", e0, b0, b1, to);
      end
      run_txn(19'h7C000);
      // m = 0x1E00 -> m9..m12 set -> byte1 bits 2,6,4,3
      checks++; if (to || e0 !== 4'd11 || b0 !== 8'h00 || b1 !== 8'h5C) begin
         failures++; $display("FAIL b2b_second got=e%0d %h %h to=%b exp=e11 00 5C to=0", e0, b0, b1, to);
      end
   endtask

`ifndef ENV_ENC_ROUND_EN
   task automatic test_roundtrip();
      logic [18:0] v, w, op, want;
      logic [12:0] m;
      int          msb, ee;
      for (int t = 0; t < 24; t++) begin
         v = 19'($urandom_range(32'h7FFFF, 32'h80));
         msb = 0;
         for (int b = 0; b < 19; b++) if (v[b]) msb = b;
         ee = msb - 7;
         run_txn(v);
         m = {b1[3], b1[4], b1[6], b1[2], b1[1], b0[7], b0[0], b0[5], b0[3], b0[4], b0[6], b0[2], b0[1]};
         w = {5'b0, 1'b1, m};
         op = (e0 <= 4'd6) ? (w >> (6 - e0)) : (w << (e0 - 6));
         want = (ee > 6) ? (v & ~((19'd1 << (ee - 6)) - 19'd1)) : v;
         checks++; if (to || e0 !== 4'(ee)) begin failures++; $display("FAIL rt_exp val=%h got=%0d exp=%0d to=%b", v, e0, ee, to); end
         checks++; if (op !== want) begin failures++; $display("FAIL rt_value val=%h got=%h exp=%h", v, op, want); end
      end
   endtask
`endif

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_value  = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_top_bit();
      test_full_scale();
      test_rounding();
      test_underflow();
      test_hold();
      test_mid_reset();
      test_back_to_back();
`ifndef ENV_ENC_ROUND_EN
      test_roundtrip();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ic9_env_encoder.md
# ic9_env_encoder

Sequential encoder producing the IC9 envelope parameter format: takes a 19-bit unsigned linear envelope value and emits the 4-bit shift code (param bus) plus the 13-bit mantissa, packed into the scrambled two-byte IC11 ROM word. It is the inverse of the IC9 param decoder, which expands bus code e and ROM mantissa into the 19-bit adder operand. It sits in the table-generation and ROM-rebuild path, fed by a value stream and draining into a byte sink.

## Interface
- No parameters; widths are fixed by the IC9 format and held in the package.
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input value offered
- in_ready  out  1  encoder idle, accepts value
- in_value  in  19  unsigned linear value (adder operand domain)
- out_valid  out  1  byte beat valid
- out_ready  in  1  sink accepts beat
- out_byte  out  8  scrambled ROM byte; even address first
- out_last  out  1  high on the second (odd-address) beat
- out_exp  out  4  param bus code e, 0..11, held for both beats
- out_uflow  out  1  value below 0x80 clamped; held for both beats

## Operation
- Decode law to invert: W = {1, m[12:0]} (14 bits); operand = W >> (6-e) for e≤6, W << (e-6) for e>6; e in 0..11; codes 12..15 are never produced.
- States IDLE, NORM, PACK0, PACK1.
- IDLE: in_ready=1. On in_valid: load sh=in_value, e=11, go NORM.
- NORM, one test per cycle:
  - If sh[18]=1: m=sh[17:5]; go PACK0.
  - Else if e=0: underflow. Set e=0, m=0, uflow=1; go PACK0.
  - Else: shift sh left by 1 with zero fill, decrement e.
- Mantissa to ROM bits (W bits stored true-polarity):
  - byte0: [1]=m0, [2]=m1, [6]=m2, [4]=m3, [3]=m4, [5]=m5, [0]=m6, [7]=m7.
  - byte1: [1]=m8, [2]=m9, [6]=m10, [4]=m11, [3]=m12; [0],[5],[7]=0.
- PACK0: present byte0 with out_last=0. Advance on out_ready.
- PACK1: present byte1 with out_last=1. On out_ready, return to IDLE.
- in_value=0 follows the underflow path.

## Timing
- Reset values: out_valid=0, in_ready=1 from the first cycle after reset, out_byte=0, out_last=0, out_exp=0, out_uflow=0, state IDLE.
- Accept at cycle N. NORM spans N+1..N+1+k, where k=11−e_final. byte0 is valid at N+2+k.
- Latency range: 2 cycles (bit 18 set) to 13 cycles (e=0).
- Handshake: out_byte, out_last, out_exp and out_uflow hold stable while out_valid && !out_ready. out_valid never drops without a transfer.
- in_ready=0 in NORM, PACK0 and PACK1; no input is taken until after the PACK1 transfer. Back-to-back throughput is one value per ≥4 cycles.
- rst mid-operation abandons the value with no partial beat. All outputs return to reset values on the next edge.

## Configuration
- ENV_ENC_ROUND_EN defined: round half-up. In the NORM exit cycle (sh[18]=1, not the underflow path), m' = m + sh[4].
  - On 13-bit carry-out: m=0 and e=e+1.
  - If e was already 11: saturate to m=0x1FFF, e=11.
  - Underflow path is unaffected.
- Undefined: truncate; sh[4:0] is discarded.

## Structure
- Package rdpiano_env_pkg holds:
  - widths ENV_LIN_W=19, ENV_MANT_W=13, ENV_EXP_W=4, ENV_EXP_MAX=11;
  - state enum env_enc_state_t;
  - byte-bit position constants for the scramble.
- Sub-module ic11_byte_scrambler: combinational, m[12:0] → {byte1, byte0}. It is shared with the ROM-compare bench.

## Test plan
- in_value=0x40000 → e=11, bytes 0x00 then 0x00, out_valid 2 cycles after accept, uflow=0.
- in_value=0x7FFFF → e=11, bytes 0xFF then 0x5E, with or without ENV_ENC_ROUND_EN.
- in_value=0x0FFFF → without macro: e=8, bytes 0xFF, 0x5E. With macro: e=9, bytes 0x00, 0x00.
- in_value=0x00080 → e=0, bytes 0x00, 0x00, latency 13. in_value=0x0003F → same outputs with out_uflow=1.
- Hold out_ready low 5 cycles in PACK0 → byte0 and exp stable, in_ready=0. Pulse rst in NORM → out_valid=0, in_ready=1 next cycle.
- Random in_value ≥ 0x80, truncate build, decode through the IC9 law → result equals in_value with the bits below the retained mantissa zeroed.
